// File: rtl/pc_gen_pkg.sv
// Shared constants and types for the fetch-address generator.
package pc_gen_pkg;

    localparam int unsigned CPU_WIDTH_DEF = 32;
    localparam int unsigned RAS_DEPTH_DEF = 4;

    // Every instruction is one 32-bit word.
    localparam int unsigned INSTR_BYTES = 4;
    localparam int unsigned ALIGN_BITS  = 2;

    // Low address bits cleared when a trap vector is loaded.
    localparam logic [ALIGN_BITS-1:0] TRAP_ALIGN_MASK = 2'b11;

    // Source selected for the next fetch address.
    typedef enum logic [2:0] {
        SRC_HOLD     = 3'd0,
        SRC_SEQ      = 3'd1,
        SRC_POP      = 3'd2,
        SRC_REDIRECT = 3'd3,
        SRC_REJECT   = 3'd4,
        SRC_TRAP     = 3'd5
    } pc_src_e;

    // Return-address-stack command bundle.
    typedef struct packed {
        logic push;
        logic pop;
        logic flush;
    } ras_cmd_t;

    // True when the low address bits describe a word-aligned target.
    function automatic logic is_aligned(input logic [ALIGN_BITS-1:0] lsbs);
        return lsbs == '0;
    endfunction

endpackage

// File: rtl/pc_gen_ras.sv
// Circular return-address stack: overwrites the oldest entry when full.
module ras_stack
    import pc_gen_pkg::*;
#(
    parameter int unsigned CPU_WIDTH = CPU_WIDTH_DEF,
    parameter int unsigned RAS_DEPTH = RAS_DEPTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic                 pop,
    input  logic                 flush,
    input  logic [CPU_WIDTH-1:0] push_addr,
    output logic [CPU_WIDTH-1:0] top,
    output logic                 empty,
    output logic                 full
);

    localparam int unsigned IDX_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(RAS_DEPTH);

    logic [CPU_WIDTH-1:0] mem [RAS_DEPTH];
    logic [IDX_W-1:0]     tos;
    logic [IDX_W-1:0]     tos_next;
    logic [CNT_W-1:0]     count;
    logic [CNT_W-1:0]     count_next;
    logic                 wr_en;
    logic [IDX_W-1:0]     wr_idx;
    logic                 pop_eff;

    // Pointer/count update and write slot selection.
    always_comb begin
        tos_next   = tos;
        count_next = count;
        wr_en      = 1'b0;
        wr_idx     = tos;
        pop_eff    = pop && (count != '0);
        if (flush) begin
            count_next = '0;
        end else if (push && pop_eff) begin
            // Old top is consumed and replaced in place.
            wr_en  = 1'b1;
            wr_idx = tos;
        end else if (push) begin
            tos_next = tos + IDX_W'(1);
            wr_en    = 1'b1;
            wr_idx   = tos + IDX_W'(1);
            if (count != DEPTH_CNT) begin
                count_next = count + CNT_W'(1);
            end
        end else if (pop_eff) begin
            tos_next   = tos - IDX_W'(1);
            count_next = count - CNT_W'(1);
        end
    end

    // Stack pointer, occupancy and status flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tos   <= '0;
            count <= '0;
            empty <= 1'b1;
            full  <= 1'b0;
        end else begin
            tos   <= tos_next;
            count <= count_next;
            empty <= (count_next == '0);
            full  <= (count_next == DEPTH_CNT);
        end
    end

    // Entry storage; contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= push_addr;
        end
    end

    assign top = mem[tos];

endmodule

// File: rtl/pc_gen.sv
// Next-fetch-address generator with trap, redirect and RAS prediction.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int unsigned          CPU_WIDTH    = CPU_WIDTH_DEF,
    parameter logic [CPU_WIDTH-1:0] RESET_VECTOR = CPU_WIDTH'(32'h0000_0000),
    parameter int unsigned          RAS_DEPTH    = RAS_DEPTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall,
    input  logic                 fetch_ready,
    input  logic                 trap_valid,
    input  logic [CPU_WIDTH-1:0] trap_target,
    input  logic                 redirect_valid,
    input  logic [CPU_WIDTH-1:0] redirect_target,
    input  logic                 call_push,
    input  logic [CPU_WIDTH-1:0] push_addr,
    input  logic                 ret_pop,
    output logic [CPU_WIDTH-1:0] curr_pc,
    output logic                 fetch_valid,
    output logic                 misalign_err,
    output logic                 ras_empty,
    output logic                 ras_full
);

    logic                 advance;
    logic [CPU_WIDTH-1:0] ras_top;
    logic [CPU_WIDTH-1:0] trap_pc;
    logic [CPU_WIDTH-1:0] seq_pc;
    logic [CPU_WIDTH-1:0] next_pc;
    pc_src_e              src;
    ras_cmd_t             ras_cmd;

    assign advance = fetch_valid & fetch_ready & ~stall;
    assign seq_pc  = curr_pc + CPU_WIDTH'(INSTR_BYTES);
    assign trap_pc = {trap_target[CPU_WIDTH-1:ALIGN_BITS],
                      ALIGN_BITS'(trap_target[ALIGN_BITS-1:0] & ~TRAP_ALIGN_MASK)};

    // Priority select of the next-address source and RAS commands.
    always_comb begin
        src           = SRC_HOLD;
        ras_cmd.push  = 1'b0;
        ras_cmd.pop   = 1'b0;
        ras_cmd.flush = 1'b0;
        if (trap_valid) begin
            src           = SRC_TRAP;
            ras_cmd.flush = 1'b1;
        end else if (redirect_valid) begin
            src = is_aligned(redirect_target[ALIGN_BITS-1:0]) ? SRC_REDIRECT : SRC_REJECT;
        end else if (advance) begin
            ras_cmd.push = call_push;
            if (ret_pop && !ras_empty) begin
                src         = SRC_POP;
                ras_cmd.pop = 1'b1;
            end else begin
                src = SRC_SEQ;
            end
        end
    end

    // Next-PC mux.
    always_comb begin
        next_pc = curr_pc;
        unique case (src)
            SRC_TRAP:     next_pc = trap_pc;
            SRC_REDIRECT: next_pc = redirect_target;
            SRC_POP:      next_pc = ras_top;
            SRC_SEQ:      next_pc = seq_pc;
            default:      next_pc = curr_pc;
        endcase
    end

    // PC register, fetch-valid and misalignment pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            curr_pc      <= RESET_VECTOR;
            fetch_valid  <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            curr_pc      <= next_pc;
            fetch_valid  <= (src != SRC_REJECT);
            misalign_err <= (src == SRC_REJECT);
        end
    end

    ras_stack #(
        .CPU_WIDTH (CPU_WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (ras_cmd.push),
        .pop       (ras_cmd.pop),
        .flush     (ras_cmd.flush),
        .push_addr (push_addr),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full)
    );

endmodule

// File: tb/tb_pc_gen.sv
// Directed and randomized checks of pc_gen against a queue-based reference model.
module tb_pc_gen;

    localparam int unsigned W  = 32;
    localparam int unsigned D  = 4;
    localparam logic [31:0] RV = 32'h0000_0000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          stall;
    logic          fetch_ready;
    logic          trap_valid;
    logic [W-1:0]  trap_target;
    logic          redirect_valid;
    logic [W-1:0]  redirect_target;
    logic          call_push;
    logic [W-1:0]  push_addr;
    logic          ret_pop;
    logic [W-1:0]  curr_pc;
    logic          fetch_valid;
    logic          misalign_err;
    logic          ras_empty;
    logic          ras_full;

    // Reference model state
    logic [31:0] m_pc;
    logic        m_fv;
    logic        m_mis;
    logic [31:0] m_ras[$];

    int n_tests = 0;
    int n_fail  = 0;

    pc_gen #(
        .CPU_WIDTH    (W),
        .RESET_VECTOR (RV),
        .RAS_DEPTH    (D)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .fetch_ready     (fetch_ready),
        .trap_valid      (trap_valid),
        .trap_target     (trap_target),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .call_push       (call_push),
        .push_addr       (push_addr),
        .ret_pop         (ret_pop),
        .curr_pc         (curr_pc),
        .fetch_valid     (fetch_valid),
        .misalign_err    (misalign_err),
        .ras_empty       (ras_empty),
        .ras_full        (ras_full)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Apply the specification's next-state rules to the model for one edge.
    task automatic model_edge();
        logic        adv;
        logic [31:0] npc;
        if (!rst_n) begin
            m_pc  = RV;
            m_fv  = 1'b0;
            m_mis = 1'b0;
            m_ras.delete();
        end else begin
            adv   = m_fv && fetch_ready && !stall;
            m_mis = 1'b0;
            m_fv  = 1'b1;
            if (trap_valid) begin
                m_pc = {trap_target[31:2], 2'b00};
                m_ras.delete();
            end else if (redirect_valid) begin
                if (redirect_target[1:0] == 2'b00) begin
                    m_pc = redirect_target;
                end else begin
                    m_mis = 1'b1;
                    m_fv  = 1'b0;
                end
            end else if (adv) begin
                if (ret_pop && m_ras.size() > 0) begin
                    npc = m_ras[$];
                    if (call_push) m_ras[m_ras.size()-1] = push_addr;
                    else void'(m_ras.pop_back());
                    m_pc = npc;
                end else begin
                    m_pc = m_pc + 32'd4;
                    if (call_push) begin
                        m_ras.push_back(push_addr);
                        if (m_ras.size() > D) void'(m_ras.pop_front());
                    end
                end
            end
        end
    endtask

    // One clock: advance the model, then compare every output.
    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check({tag, ".pc"},    curr_pc,      m_pc);
        check({tag, ".fv"},    fetch_valid,  m_fv);
        check({tag, ".mis"},   misalign_err, m_mis);
        check({tag, ".empty"}, ras_empty,    32'(m_ras.size() == 0));
        check({tag, ".full"},  ras_full,     32'(m_ras.size() == D));
    endtask

    task automatic idle_inputs();
        stall           = 1'b0;
        fetch_ready     = 1'b1;
        trap_valid      = 1'b0;
        trap_target     = '0;
        redirect_valid  = 1'b0;
        redirect_target = '0;
        call_push       = 1'b0;
        push_addr       = '0;
        ret_pop         = 1'b0;
    endtask

    initial begin
        logic [31:0] prev_pc;
        logic [31:0] r;
        idle_inputs();
        fetch_ready = 1'b0;
        rst_n       = 1'b0;
        m_pc = RV; m_fv = 1'b0; m_mis = 1'b0;

        // Reset, then three ready cycles
        step("rst0");
        step("rst1");
        check("rst.pc", curr_pc, 32'h0);
        check("rst.fv", fetch_valid, 32'h0);
        check("rst.empty", ras_empty, 32'h1);
        rst_n = 1'b1;
        fetch_ready = 1'b1;
        step("rel1"); check("rel1.pc_c", curr_pc, 32'h0); check("rel1.fv_c", fetch_valid, 32'h1);
        step("rel2"); check("rel2.pc_c", curr_pc, 32'h4);
        step("rel3"); check("rel3.pc_c", curr_pc, 32'h8);

        // Redirect under stall, then a misaligned redirect
        stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h100;
        step("redir"); check("redir.pc_c", curr_pc, 32'h100);
        redirect_target = 32'h102;
        step("misal"); check("misal.pc_c", curr_pc, 32'h100); check("misal.mis_c", misalign_err, 32'h1);
        check("misal.fv_c", fetch_valid, 32'h0);
        redirect_valid = 1'b0; stall = 1'b0;
        step("misal2"); check("misal2.mis_c", misalign_err, 32'h0);
        step("misal3");

        // Trap beats redirect and flushes the RAS
        call_push = 1'b1; push_addr = 32'h77;
        step("pre_trap");
        call_push = 1'b0;
        trap_valid = 1'b1; trap_target = 32'h203; redirect_valid = 1'b1; redirect_target = 32'h300;
        step("trap"); check("trap.pc_c", curr_pc, 32'h200); check("trap.empty_c", ras_empty, 32'h1);
        trap_valid = 1'b0; redirect_valid = 1'b0;

        // Overfill the RAS then drain it
        call_push = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            push_addr = 32'(i * 16);
            step("push");
        end
        check("push.full_c", ras_full, 32'h1);
        call_push = 1'b0; ret_pop = 1'b1;
        step("pop1"); check("pop1.pc_c", curr_pc, 32'h50);
        step("pop2"); check("pop2.pc_c", curr_pc, 32'h40);
        step("pop3"); check("pop3.pc_c", curr_pc, 32'h30);
        step("pop4"); check("pop4.pc_c", curr_pc, 32'h20);
        prev_pc = curr_pc;
        step("pop5"); check("pop5.pc_c", curr_pc, prev_pc + 32'd4);
        ret_pop = 1'b0;

        // Address wrap
        redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
        step("wrap0");
        redirect_valid = 1'b0;
        step("wrap1"); check("wrap.pc_c", curr_pc, 32'h0);

        // Reset with a full RAS and a concurrent trap
        call_push = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_addr = 32'h1000 + 32'(i * 4);
            step("fill");
        end
        call_push = 1'b0;
        check("fill.full_c", ras_full, 32'h1);
        rst_n = 1'b0; trap_valid = 1'b1; trap_target = 32'h400;
        step("mrst"); check("mrst.pc_c", curr_pc, RV); check("mrst.empty_c", ras_empty, 32'h1);
        rst_n = 1'b1; trap_valid = 1'b0;
        step("mrel");

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst_n       = ($urandom_range(0, 199) != 0);
            stall       = ($urandom_range(0, 3) == 0);
            fetch_ready = ($urandom_range(0, 3) != 0);
            trap_valid  = ($urandom_range(0, 39) == 0);
            trap_target = $urandom;
            redirect_valid = ($urandom_range(0, 11) == 0);
            r = $urandom;
            if ($urandom_range(0, 1) == 0) r[1:0] = 2'b00;
            redirect_target = r;
            call_push = ($urandom_range(0, 2) == 0);
            r = $urandom;
            push_addr = r;
            ret_pop   = ($urandom_range(0, 2) == 0);
            step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 The block SHALL have parameter CPU_WIDTH, default 32: PC and address width in bits.
REQ-002 The block SHALL have parameter RESET_VECTOR, default 32'h0000_0000: first fetch address after reset.
REQ-003 The block SHALL have parameter RAS_DEPTH, default 4 (power of two, >=2): return-address-stack entries.
REQ-004 The block SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-006 The block SHALL have port stall, input, 1: hold the sequential PC.
REQ-007 The block SHALL have port fetch_ready, input, 1: fetch stage accepts curr_pc.
REQ-008 The block SHALL have ports trap_valid, input, 1, and trap_target, input, CPU_WIDTH: trap/exception vector.
REQ-009 The block SHALL have ports redirect_valid, input, 1, and redirect_target, input, CPU_WIDTH: resolved branch/jump target.
REQ-010 The block SHALL have ports call_push, input, 1, and push_addr, input, CPU_WIDTH: predicted call and its return address.
REQ-011 The block SHALL have port ret_pop, input, 1: predicted return, take the RAS top.
REQ-012 The block SHALL have port curr_pc, output, CPU_WIDTH: current fetch address (registered).
REQ-013 The block SHALL have port fetch_valid, output, 1: curr_pc is valid to fetch.
REQ-014 The block SHALL have ports misalign_err, output, 1 (one-cycle pulse), ras_empty, output, 1, and ras_full, output, 1.

Function
REQ-015 "Advance" SHALL mean fetch_valid & fetch_ready & ~stall.
REQ-016 Next-PC priority SHALL be trap_valid > redirect_valid > (advance & ret_pop & ~ras_empty) > (advance: curr_pc+4) > hold.
REQ-017 Trap SHALL load trap_target with bits [1:0] forced to 0, irrespective of stall or fetch_ready, and SHALL empty the RAS.
REQ-018 A redirect with redirect_target[1:0]==0 SHALL load redirect_target irrespective of stall or fetch_ready, with RAS untouched.
REQ-019 A redirect with redirect_target[1:0]!=0 SHALL be rejected: PC holds, misalign_err=1 for the following cycle only.
REQ-020 Sequential increment SHALL be modulo 2^CPU_WIDTH, so {CPU_WIDTH{1'b1}}-3 steps to 0.
REQ-021 call_push and ret_pop SHALL take effect only on an advance cycle with no trap or redirect, and are otherwise ignored.
REQ-022 Pop SHALL supply the top entry as next PC and decrement the count; a pop on an empty RAS SHALL fall back to curr_pc+4.
REQ-023 Push SHALL write push_addr above the top; a push on a full RAS SHALL overwrite the oldest entry (circular), with count staying RAS_DEPTH.
REQ-024 Simultaneous push and pop SHALL take the old top as next PC, then write push_addr into that slot, leaving the count unchanged.
REQ-025 ras_empty SHALL equal (count==0) and ras_full SHALL equal (count==RAS_DEPTH), both registered state.
REQ-026 fetch_valid SHALL be 1 in every cycle after reset release, and SHALL be 0 in the cycle following a rejected redirect.

Reset
REQ-027 While rst_n=0 at a clock edge, the block SHALL set curr_pc=RESET_VECTOR, fetch_valid=0, misalign_err=0, and RAS count=0 (ras_empty=1, ras_full=0).
REQ-028 RAS entry contents SHALL need no reset.
REQ-029 Reset SHALL override every concurrent input, including trap_valid.
REQ-030 On the first edge with rst_n=1, the block SHALL set fetch_valid=1 with curr_pc still RESET_VECTOR.

Structure
REQ-031 CPU_WIDTH and the instruction size constant (4) SHALL come from the shared defines package, and the trap-alignment mask SHALL be defined there.
REQ-032 The RAS SHALL be a sub-module ras_stack (params CPU_WIDTH, RAS_DEPTH; push/pop/flush in; top/empty/full out).
REQ-033 pc_gen SHALL contain only the next-PC mux, the PC register and the misalign flag.

Verification
REQ-034 A bench SHALL check: reset, then 3 cycles with fetch_ready=1 -> curr_pc 0x0, 0x0, 0x4, 0x8 (fetch_valid 0,1,1,1).
REQ-035 A bench SHALL check: stall=1 with redirect_valid=1, target 0x100 -> curr_pc=0x100 next cycle; a target of 0x102 -> PC holds, misalign_err pulses one cycle.
REQ-036 A bench SHALL check: trap_valid and redirect_valid together, trap_target 0x203 -> curr_pc=0x200, ras_empty=1.
REQ-037 A bench SHALL check: push 0x10, 0x20, 0x30, 0x40, 0x50 (depth 4) then 5 pops -> next PCs 0x50, 0x40, 0x30, 0x20, then curr_pc+4.
REQ-038 A bench SHALL check: curr_pc=0xFFFF_FFFC advancing -> 0x0000_0000.
REQ-039 A bench SHALL check: rst_n low mid-sequence with RAS full -> curr_pc=RESET_VECTOR, ras_empty=1 next cycle.
